// File: rtl/oflow_score_calc_min_sched_if.sv
// oflow_score_calc_min_sched_if: lane pulse/status bundle between the score-calc scheduler and its environment.
interface oflow_score_calc_min_sched_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic [N_CH-1:0]  ch_en;
    logic [N_CH-1:0]  done_similarity_metric;
    logic [N_CH-1:0]  done_calc_min;
    logic             done_read;
    logic [N_CH-1:0]  start_calc_min;
    logic             done_score_calc;
    logic [CNT_W-1:0] calc_cnt;
    logic             err_protocol;
    logic             busy;

    modport master (
        output ch_en, done_similarity_metric, done_calc_min, done_read,
        input  start_calc_min, done_score_calc, calc_cnt, err_protocol, busy
    );

    modport slave (
        input  ch_en, done_similarity_metric, done_calc_min, done_read,
        output start_calc_min, done_score_calc, calc_cnt, err_protocol, busy
    );
endinterface

// File: rtl/oflow_score_calc_min_sched.sv
// oflow_score_calc_min_sched: per-lane IDLE/ARM/CALC sequencing of calc_min units with final-batch completion detection.
module oflow_score_calc_min_sched #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset_N,
    oflow_score_calc_min_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, CALC} state_e;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [N_CH-1:0]  en_mask_q, en_mask_d;
    logic [N_CH-1:0]  fin_q, fin_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_CH-1:0]  idle_v, arm_v, calc_v, en_eff, valid_dcm, fin_all;
    logic             cond, bad;
    logic [4:0]       pop;
    logic [CNT_W+4:0] sum;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            for (int i = 0; i < N_CH; i++) state_q[i] <= IDLE;
            en_mask_q <= '0;
            fin_q     <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
            en_mask_q <= en_mask_d;
            fin_q     <= fin_d;
            last_q    <= last_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        idle_v = '0;
        arm_v  = '0;
        calc_v = '0;
        for (int i = 0; i < N_CH; i++) begin
            idle_v[i] = state_q[i] == IDLE;
            arm_v[i]  = state_q[i] == ARM;
            calc_v[i] = state_q[i] == CALC;
        end
        // the mask is transparent while fully idle so a batch is accepted on the very first edge
        en_eff    = (&idle_v && !last_q) ? bus.ch_en : en_mask_q;
        en_mask_d = en_eff;
        valid_dcm = bus.done_calc_min & calc_v;
        bad = |(bus.done_calc_min & ~calc_v)
            | |(bus.done_similarity_metric & en_eff & ~idle_v)
            | (bus.done_read & last_q);
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            if (idle_v[i] && bus.done_similarity_metric[i] && en_eff[i]) state_d[i] = ARM;
            else if (arm_v[i]) state_d[i] = CALC;
            else if (valid_dcm[i]) state_d[i] = IDLE;
        end
        fin_all = fin_q | (valid_dcm & {N_CH{last_q}});
        cond    = last_q && (|en_mask_q) && ((fin_all & en_mask_q) == en_mask_q);
        fin_d   = cond ? '0 : fin_all;
        last_d  = bus.done_read ? 1'b1 : (cond ? 1'b0 : last_q);
        done_d  = cond;
        err_d   = err_q | bad;
        pop = '0;
        for (int i = 0; i < N_CH; i++) pop = pop + 5'(valid_dcm[i]);
        sum   = (done_q ? '0 : {5'b0, cnt_q}) + {{CNT_W{1'b0}}, pop};
        cnt_d = (|sum[CNT_W+4:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end

    assign bus.start_calc_min  = arm_v;
    assign bus.done_score_calc = done_q;
    assign bus.calc_cnt        = cnt_q;
    assign bus.err_protocol    = err_q;
    assign bus.busy            = ~(&idle_v) | last_q;
endmodule

// File: doc/oflow_score_calc_min_sched.md
OFLOW_SCORE_CALC_MIN_SCHED -- requirements
Module: oflow_score_calc_min_sched

Interface
REQ-001 Parameter N_CH, default 4, SHALL set the number of independent score-calc lanes (legal range 1..16).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the completion counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_N  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ch_en  input  N_CH  SHALL be the lane enable mask, sampled per REQ-016.
REQ-006 done_similarity_metric  input  N_CH  SHALL carry per-lane one-cycle pulses meaning "similarity metric for this batch is ready".
REQ-007 done_calc_min  input  N_CH  SHALL carry per-lane one-cycle pulses meaning "min calculation finished".
REQ-008 done_read  input  1  SHALL be a one-cycle pulse meaning "the buffer has issued its final batch".
REQ-009 start_calc_min  output  N_CH  SHALL carry per-lane one-cycle start pulses to the calc_min units.
REQ-010 done_score_calc  output  1  SHALL be a registered one-cycle pulse meaning "the final batch is complete on all enabled lanes".
REQ-011 calc_cnt  output  CNT_W  SHALL report the calc_min completions since the last done_score_calc.
REQ-012 err_protocol  output  1  SHALL be a sticky protocol-violation flag.
REQ-013 busy  output  1  SHALL be high when any lane is outside IDLE or last=1.

Function
REQ-014 Each lane SHALL run an independent FSM with states IDLE, ARM and CALC.
REQ-015 Lane transitions:
- IDLE->ARM when done_similarity_metric[i] and en_mask[i].
- ARM->CALC unconditionally after 1 cycle.
- CALC->IDLE on done_calc_min[i].
REQ-016 en_mask SHALL load ch_en on every cycle in which all lanes are IDLE and last=0; otherwise it SHALL hold its value.
REQ-017 start_calc_min[i] SHALL be high exactly while lane i is in ARM, i.e. one cycle after done_similarity_metric[i] (latency 1).
REQ-018 A done_similarity_metric[i] pulse on a disabled lane SHALL be ignored without an error.
REQ-019 Register last SHALL set on done_read and clear in the cycle done_score_calc is driven high; done_read has priority if both occur.
REQ-020 fin[i] SHALL set when lane i leaves CALC via done_calc_min[i] while last=1.
REQ-021 done_score_calc SHALL pulse in the cycle after the first cycle in which last=1, en_mask!=0, and every en_mask lane has fin (including fins being set that same cycle).
REQ-022 In the done_score_calc cycle, all fin bits SHALL clear.
REQ-023 Lanes completing simultaneously SHALL each count toward the completion condition; no completion is lost.
REQ-024 calc_cnt SHALL increment by popcount of the valid done_calc_min pulses each cycle and saturate at 2^CNT_W-1.
REQ-025 calc_cnt SHALL reset to 0 in the cycle after done_score_calc; a completion in that same cycle SHALL load its popcount instead.
REQ-026 err_protocol SHALL set, and stay set until reset, on any of:
- done_calc_min[i] while lane i is not in CALC;
- done_similarity_metric[i] on an enabled lane not in IDLE;
- done_read while last=1.
REQ-027 An offending pulse SHALL NOT change lane state.

Reset
REQ-028 While reset_N=0, all of the following SHALL be 0:
- lane states = IDLE;
- en_mask, fin and last;
- start_calc_min, done_score_calc, calc_cnt and err_protocol.
REQ-029 Reset asserted mid-operation SHALL abort in-flight lanes immediately, with no done_score_calc pulse.
REQ-030 After reset release, the block SHALL accept a new batch on the first clock edge.

Verification
REQ-031 N_CH=4, ch_en=4'b1111, pulse done_similarity_metric=4'b0001 at cycle 0 -> start_calc_min=4'b0001 only at cycle 1; done_calc_min[0] at cycle 5 -> calc_cnt=1 and done_score_calc stays 0.
REQ-032 done_read, then all four lanes finish together at cycle t -> done_score_calc=1 at t+1 only; at t+2 calc_cnt=0 and last=0.
REQ-033 ch_en=4'b0101 latched while idle; lanes 0 and 2 finish at cycles 10 and 14 with last=1 -> done_score_calc at 15; pulses on lanes 1 and 3 ignored with err_protocol=0.
REQ-034 done_calc_min[2] while lane 2 is IDLE -> err_protocol=1 from the next cycle and held; lane states unchanged.
REQ-035 CNT_W=3 with 9 completions without last -> calc_cnt=7 (saturated).
REQ-036 reset_N low while lanes are in CALC and last=1 -> all outputs 0 asynchronously; no done_score_calc after release.
